// File: rtl/rc5_sched_ctrl_if.sv
// Handshake and RAM/engine control bundle between the RC5 scheduler and its
// requesters and datapath. The scheduler side uses the slave modport.
interface rc5_sched_ctrl_if #(
  parameter int SAW = 5,
  parameter int LAW = 2,
  parameter int KAW = 4
);
  logic           key_load;
  logic           req_enc;
  logic           req_dec;
  logic           gnt_enc;
  logic           gnt_dec;
  logic           done_enc;
  logic           done_dec;
  logic           ks_valid;
  logic           busy;
  logic [1:0]     ks_phase;
  logic [KAW-1:0] key_addr;
  logic [LAW-1:0] l_addr;
  logic           l_we;
  logic [SAW-1:0] s_addr_a;
  logic [SAW-1:0] s_addr_b;
  logic           s_we;
  logic           eng_en;
  logic           eng_dir;
  logic [3:0]     eng_round;

  modport master (
    output key_load, req_enc, req_dec,
    input  gnt_enc, gnt_dec, done_enc, done_dec, ks_valid, busy, ks_phase,
           key_addr, l_addr, l_we, s_addr_a, s_addr_b, s_we,
           eng_en, eng_dir, eng_round
  );

  modport slave (
    input  key_load, req_enc, req_dec,
    output gnt_enc, gnt_dec, done_enc, done_dec, ks_valid, busy, ks_phase,
           key_addr, l_addr, l_we, s_addr_a, s_addr_b, s_we,
           eng_en, eng_dir, eng_round
  );
endinterface

// File: rtl/rc5_sched_ctrl.sv
// RC5 key-schedule sequencer and round-engine arbiter: drives RAM addresses and
// enables for key expansion, then grants the round engine to enc/dec requesters.
module rc5_sched_ctrl #(
  parameter int R   = 12,
  parameter int B   = 16,
  parameter int C   = 4,
  parameter int T   = 26,
  parameter int SAW = 5,
  parameter int LAW = 2,
  parameter int KAW = 4
) (
  input  logic            clk,
  input  logic            rst,
  rc5_sched_ctrl_if.slave bus
);

  localparam int WB = 4;
  localparam int N  = 3 * ((T > C) ? T : C);
  localparam int CW = $clog2(N);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_L = 3'd1;
  localparam logic [2:0] S_INIT_S = 3'd2;
  localparam logic [2:0] S_MIX    = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SAW-1:0] i_q, i_d;
  logic [LAW-1:0] j_q, j_d;
  logic [3:0]     rnd_q, rnd_d;
  logic           dir_q, dir_d;
  logic           last_q, last_d;
  logic           pick_dec;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i_d      = i_q;
    j_d      = j_q;
    rnd_d    = rnd_q;
    dir_d    = dir_q;
    last_d   = last_q;
    // last_q=1 means decipher was served last, so encipher wins a tie.
    pick_dec = bus.req_dec & (~bus.req_enc | ~last_q);
    case (state_q)
      S_IDLE: begin
        if (bus.key_load) begin
          state_d = S_LOAD_L;
          cnt_d   = '0;
        end
      end
      S_LOAD_L: begin
        if (cnt_q == CW'(B - 1)) begin
          state_d = S_INIT_S;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_INIT_S: begin
        if (cnt_q == CW'(T - 2)) begin
          state_d = S_MIX;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MIX: begin
        i_d = (i_q == SAW'(T - 1)) ? '0 : i_q + SAW'(1);
        j_d = (j_q == LAW'(C - 1)) ? '0 : j_q + LAW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_READY;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READY: begin
        if (bus.key_load) begin
          state_d = S_LOAD_L;
          cnt_d   = '0;
        end else if (bus.req_enc | bus.req_dec) begin
          state_d = S_RUN;
          cnt_d   = '0;
          dir_d   = pick_dec;
          last_d  = pick_dec;
          rnd_d   = pick_dec ? 4'(R) : 4'd0;
        end
      end
      S_RUN: begin
        rnd_d = dir_q ? rnd_q - 4'd1 : rnd_q + 4'd1;
        if (cnt_q == CW'(R)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_READY;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      rnd_q   <= '0;
      dir_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rnd_q   <= rnd_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
    end
  end

  // Outputs are pure decodes of registered state; unused addresses stay zero.
  logic           gnt_on;
  logic [1:0]     ks_phase;
  logic [KAW-1:0] key_addr;
  logic [LAW-1:0] l_addr;
  logic           l_we;
  logic [SAW-1:0] s_addr_a;
  logic [SAW-1:0] s_addr_b;
  logic           s_we;
  logic           eng_en;
  logic [3:0]     eng_round;

  always_comb begin
    ks_phase  = 2'd0;
    key_addr  = '0;
    l_addr    = '0;
    l_we      = 1'b0;
    s_addr_a  = '0;
    s_addr_b  = '0;
    s_we      = 1'b0;
    eng_en    = 1'b0;
    eng_round = 4'd0;
    case (state_q)
      S_LOAD_L: begin
        ks_phase = 2'd1;
        key_addr = KAW'(cnt_q);
        l_addr   = LAW'(cnt_q / CW'(WB));
        l_we     = 1'b1;
      end
      S_INIT_S: begin
        ks_phase = 2'd2;
        s_addr_a = SAW'(cnt_q) + SAW'(1);
        s_we     = 1'b1;
      end
      S_MIX: begin
        ks_phase = 2'd3;
        s_addr_a = i_q;
        l_addr   = j_q;
        s_we     = 1'b1;
        l_we     = 1'b1;
      end
      S_RUN: begin
        eng_en    = 1'b1;
        eng_round = rnd_q;
        s_addr_a  = SAW'({rnd_q, 1'b0});
        s_addr_b  = SAW'({rnd_q, 1'b1});
      end
      default: ;
    endcase
  end

  assign gnt_on        = (state_q == S_RUN) | (state_q == S_DONE);
  assign bus.gnt_enc   = gnt_on & ~dir_q;
  assign bus.gnt_dec   = gnt_on & dir_q;
  assign bus.done_enc  = (state_q == S_DONE) & ~dir_q;
  assign bus.done_dec  = (state_q == S_DONE) & dir_q;
  assign bus.ks_valid  = (state_q == S_READY);
  assign bus.busy      = (state_q != S_IDLE) & (state_q != S_READY);
  assign bus.eng_dir   = (state_q == S_RUN) & dir_q;
  assign bus.ks_phase  = ks_phase;
  assign bus.key_addr  = key_addr;
  assign bus.l_addr    = l_addr;
  assign bus.l_we      = l_we;
  assign bus.s_addr_a  = s_addr_a;
  assign bus.s_addr_b  = s_addr_b;
  assign bus.s_we      = s_we;
  assign bus.eng_en    = eng_en;
  assign bus.eng_round = eng_round;

endmodule
